// File: rtl/tiny_cpu_pkg.sv
// tiny_cpu_pkg: shared definitions for the multicycle tiny CPU.
//   - 4-bit opcode constants
//   - FSM state encoding (IDLE, EXEC, MUL)
//   - instruction field helpers parametrised by the register address width
package tiny_cpu_pkg;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_XOR = 4'b0100;
  localparam logic [3:0] OP_SLT = 4'b0101;
  localparam logic [3:0] OP_SHL = 4'b0110;
  localparam logic [3:0] OP_SHR = 4'b0111;
  localparam logic [3:0] OP_MUL = 4'b1000;
  localparam logic [3:0] OP_OUT = 4'b1011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    MUL  = 2'd2
  } state_e;

  // Instruction layout: {op[3:0], a[R-1:0], b[R-1:0]}
  function automatic logic [3:0] instr_op(input logic [31:0] ir, input int regbits);
    return ir[2*regbits +: 4];
  endfunction

  function automatic logic [31:0] instr_a(input logic [31:0] ir, input int regbits);
    return (ir >> regbits) & ((32'd1 << regbits) - 32'd1);
  endfunction

  function automatic logic [31:0] instr_b(input logic [31:0] ir, input int regbits);
    return ir & ((32'd1 << regbits) - 32'd1);
  endfunction

  function automatic logic is_ldi(input logic [3:0] op);
    return op[3:2] == 2'b11;
  endfunction

endpackage

// File: rtl/regfile_mc.sv
// regfile_mc: register file with two asynchronous read ports and one
// synchronous write port; all registers reset asynchronously to zero.
//   clk, rst_n       clock, async active-low reset
//   ra_a_i, ra_b_i   read addresses
//   rd_a_o, rd_b_o   read data
//   we_i, wa_i, wd_i write enable / address / data
module regfile_mc #(
  parameter int WORDSIZE = 8,
  parameter int REGBITS  = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [REGBITS-1:0]  ra_a_i,
  input  logic [REGBITS-1:0]  ra_b_i,
  output logic [WORDSIZE-1:0] rd_a_o,
  output logic [WORDSIZE-1:0] rd_b_o,
  input  logic                we_i,
  input  logic [REGBITS-1:0]  wa_i,
  input  logic [WORDSIZE-1:0] wd_i
);

  localparam int NREGS = 2**REGBITS;

  logic [WORDSIZE-1:0] regs_q [NREGS];

  assign rd_a_o = regs_q[ra_a_i];
  assign rd_b_o = regs_q[ra_b_i];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (we_i) begin
      regs_q[wa_i] <= wd_i;
    end
  end

endmodule

// File: rtl/tiny_cpu_mc.sv
// tiny_cpu_mc: multicycle tiny CPU core with valid/ready instruction intake,
// sequential shift-add multiplier, registered zero flag and result strobe.
//   clk, rst_n   clock, async active-low reset
//   instr_valid  instruction offered
//   instr_ready  core accepts (high only in IDLE)
//   instr        {op, a, b}
//   res_valid    one-cycle pulse when res updates
//   res          last written-back / OUT value
//   zf           zero flag of the last ALU/MUL result
//   busy         high in EXEC or MUL
module tiny_cpu_mc
  import tiny_cpu_pkg::*;
#(
  parameter int WORDSIZE = 8,
  parameter int REGBITS  = 2,
  localparam int IW      = 4 + 2*REGBITS
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                instr_valid,
  output logic                instr_ready,
  input  logic [IW-1:0]       instr,
  output logic                res_valid,
  output logic [WORDSIZE-1:0] res,
  output logic                zf,
  output logic                busy
);

  localparam int CW = $clog2(WORDSIZE);
  localparam logic [WORDSIZE-1:0] WS = WORDSIZE'(WORDSIZE);

  state_e              state_q, state_d;
  logic [IW-1:0]       ir_q, ir_d;
  logic [WORDSIZE-1:0] res_q, res_d;
  logic                zf_q, zf_d;
  logic                res_valid_q, res_valid_d;
  logic [WORDSIZE-1:0] acc_q, acc_d, mcand_q, mcand_d, mplier_q, mplier_d;
  logic [CW-1:0]       cnt_q, cnt_d;

  logic [3:0]          op;
  logic [REGBITS-1:0]  fa, fb;
  logic [WORDSIZE-1:0] ra, rb, alu, ldi_val, mul_sum, wd;
  logic [REGBITS+1:0]  ldi_imm;
  logic                we;

  assign op      = instr_op(32'(ir_q), REGBITS);
  assign fa      = REGBITS'(instr_a(32'(ir_q), REGBITS));
  assign fb      = REGBITS'(instr_b(32'(ir_q), REGBITS));
  assign ldi_imm = {op[1:0], fb};
  assign ldi_val = WORDSIZE'($signed(ldi_imm));
  assign mul_sum = acc_q + (mplier_q[0] ? mcand_q : '0);

  regfile_mc #(.WORDSIZE(WORDSIZE), .REGBITS(REGBITS)) u_rf (
    .clk    (clk),
    .rst_n  (rst_n),
    .ra_a_i (fa),
    .ra_b_i (fb),
    .rd_a_o (ra),
    .rd_b_o (rb),
    .we_i   (we),
    .wa_i   (fa),
    .wd_i   (wd)
  );

  always_comb begin
    alu = '0;
    case (op)
      OP_ADD: alu = ra + rb;
      OP_SUB: alu = ra - rb;
      OP_AND: alu = ra & rb;
      OP_OR:  alu = ra | rb;
      OP_XOR: alu = ra ^ rb;
      OP_SLT: alu[0] = $signed(ra) < $signed(rb);
      OP_SHL: alu = (rb >= WS) ? '0 : ra << rb;
      OP_SHR: alu = (rb >= WS) ? '0 : ra >> rb;
      default: alu = '0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    ir_d        = ir_q;
    acc_d       = acc_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    cnt_d       = cnt_q;
    res_d       = res_q;
    zf_d        = zf_q;
    res_valid_d = 1'b0;
    we          = 1'b0;
    wd          = alu;
    case (state_q)
      IDLE: begin
        if (instr_valid) begin
          ir_d    = instr;
          state_d = EXEC;
        end
      end
      EXEC: begin
        state_d = IDLE;
        if (!op[3]) begin
          we   = 1'b1;
          wd   = alu;
          zf_d = (alu == '0);
        end else if (op == OP_MUL) begin
          acc_d    = '0;
          mcand_d  = ra;
          mplier_d = rb;
          cnt_d    = CW'(WORDSIZE - 1);
          state_d  = MUL;
        end else if (op == OP_OUT) begin
          res_d       = rb;
          res_valid_d = 1'b1;
        end else if (is_ldi(op)) begin
          we = 1'b1;
          wd = ldi_val;
        end
      end
      MUL: begin
        // Last iteration's partial sum is written back directly, so WORDSIZE
        // iterations fit in WORDSIZE MUL cycles.
        if (cnt_q == '0) begin
          we      = 1'b1;
          wd      = mul_sum;
          zf_d    = (mul_sum == '0);
          state_d = IDLE;
        end else begin
          acc_d    = mul_sum;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    if (we) begin
      res_d       = wd;
      res_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ir_q        <= '0;
      res_q       <= '0;
      zf_q        <= 1'b0;
      res_valid_q <= 1'b0;
      acc_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      ir_q        <= ir_d;
      res_q       <= res_d;
      zf_q        <= zf_d;
      res_valid_q <= res_valid_d;
      acc_q       <= acc_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      cnt_q       <= cnt_d;
    end
  end

  assign instr_ready = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign res         = res_q;
  assign zf          = zf_q;
  assign res_valid   = res_valid_q;

endmodule

// File: tb/tb_tiny_cpu_mc.sv
// Testbench for tiny_cpu_mc at WORDSIZE=8, REGBITS=2: instruction-level model
// with latency bookkeeping, per-cycle output comparison and literal spot checks.
module tb_tiny_cpu_mc;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       instr_valid = 1'b0;
  logic [7:0] instr = 8'h00;
  logic       instr_ready, res_valid, zf, busy;
  logic [7:0] res;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tiny_cpu_mc #(.WORDSIZE(8), .REGBITS(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .res_valid   (res_valid),
    .res         (res),
    .zf          (zf),
    .busy        (busy)
  );

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Instruction-level model: effect computed at accept, applied after latency.
  logic [7:0] m_r [4] = '{default: 8'h00};
  int         m_cnt = 0;
  logic [7:0] m_res = 8'h00;
  logic       m_zf = 1'b0, m_vld = 1'b0;
  logic       p_we = 1'b0, p_out = 1'b0, p_zf = 1'b0;
  int         p_a = 0;
  logic [7:0] p_val = 8'h00;

  always @(posedge clk or negedge rst_n) begin : model
    logic [7:0] x, y;
    int v;
    if (!rst_n) begin
      foreach (m_r[i]) m_r[i] = 8'h00;
      m_cnt = 0; m_res = 8'h00; m_zf = 1'b0; m_vld = 1'b0;
      p_we = 1'b0; p_out = 1'b0; p_zf = 1'b0;
    end else begin
      m_vld = 1'b0;
      if (m_cnt > 0) begin
        m_cnt--;
        if (m_cnt == 0) begin
          if (p_we) m_r[p_a] = p_val;
          if (p_we || p_out) begin
            m_res = p_val;
            m_vld = 1'b1;
          end
          if (p_zf) m_zf = (p_val == 8'h00);
        end
      end else if (instr_valid) begin
        p_a = int'(instr[3:2]);
        x = m_r[instr[3:2]];
        y = m_r[instr[1:0]];
        p_we = 1'b1; p_out = 1'b0; p_zf = 1'b1; m_cnt = 1;
        case (instr[7:4])
          4'd0: p_val = x + y;
          4'd1: p_val = x - y;
          4'd2: p_val = x & y;
          4'd3: p_val = x | y;
          4'd4: p_val = x ^ y;
          4'd5: p_val = ($signed(x) < $signed(y)) ? 8'd1 : 8'd0;
          4'd6: p_val = (y >= 8'd8) ? 8'd0 : x << y;
          4'd7: p_val = (y >= 8'd8) ? 8'd0 : x >> y;
          4'd8: begin p_val = 8'(int'(x) * int'(y)); m_cnt = 9; end
          4'd9, 4'd10: begin p_we = 1'b0; p_zf = 1'b0; end
          4'd11: begin p_we = 1'b0; p_out = 1'b1; p_zf = 1'b0; p_val = y; end
          default: begin
            p_zf = 1'b0;
            v = int'(instr[5:4]) * 4 + int'(instr[1:0]);
            if (v >= 8) v -= 16;
            p_val = 8'(v);
          end
        endcase
      end
    end
  end

  always @(negedge clk) begin
    #1;
    chk1("instr_ready", instr_ready, m_cnt == 0);
    chk1("busy", busy, m_cnt != 0);
    chk1("res_valid", res_valid, m_vld);
    chk8("res", res, m_res);
    chk1("zf", zf, m_zf);
  end

  task automatic issue(input logic [7:0] v, input bit hold);
    int n = 0;
    @(negedge clk);
    instr = v;
    instr_valid = 1'b1;
    while (!instr_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) begin
      checks++; errors++;
      $display("FAIL accept_timeout: got no instr_ready expected ready within 40 cycles");
    end
    @(posedge clk);
    if (!hold) begin
      #1;
      instr_valid = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (!instr_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) begin
      checks++; errors++;
      $display("FAIL idle_timeout: got busy expected idle within 40 cycles");
    end
  endtask

  task automatic run(input logic [7:0] v, input string name, input logic [7:0] exp_res, input logic exp_zf);
    issue(v, 1'b0);
    wait_idle();
    chk8({name, "_res"}, res, exp_res);
    chk1({name, "_zf"}, zf, exp_zf);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200us");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int bc;
    repeat (3) @(negedge clk);
    #2;
    chk1("rst_ready", instr_ready, 1'b1);
    chk1("rst_busy", busy, 1'b0);
    chk8("rst_res", res, 8'h00);
    chk1("rst_zf", zf, 1'b0);
    chk1("rst_valid", res_valid, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    run(8'hD5, "ldi_r1", 8'h05, 1'b0);
    run(8'hF9, "ldi_r2", 8'hFD, 1'b0);
    run(8'h06, "add", 8'h02, 1'b0);
    run(8'h15, "sub", 8'h00, 1'b1);
    run(8'hDF, "ldi_r3", 8'h07, 1'b1);

    // MUL r3,r2 with instr_valid held high (a NOP waits behind it)
    issue(8'h8E, 1'b1);
    #1 instr = 8'h90;
    bc = 0;
    @(negedge clk);
    while (busy && bc < 40) begin
      bc++;
      @(negedge clk);
    end
    checks++;
    if (bc != 9) begin
      errors++;
      $display("FAIL mul_busy_cycles: got %0d expected 9", bc);
    end
    chk8("mul_res", res, 8'hEB);
    chk1("mul_zf", zf, 1'b0);
    @(posedge clk);
    #1 instr_valid = 1'b0;
    wait_idle();
    chk8("nop_after_mul_res", res, 8'hEB);

    run(8'hB3, "out_r3", 8'hEB, 1'b0);
    run(8'h90, "nop", 8'hEB, 1'b0);
    run(8'h6E, "shl_big", 8'h00, 1'b1);
    run(8'h59, "slt", 8'h01, 1'b0);
    run(8'h4B, "xor", 8'h01, 1'b0);
    run(8'hF3, "ldi_r0", 8'hFF, 1'b0);
    run(8'h72, "shr", 8'h7F, 1'b0);
    run(8'h34, "or", 8'h7F, 1'b0);
    run(8'h22, "and", 8'h01, 1'b0);
    run(8'hB1, "out_r1", 8'h7F, 1'b0);

    // Reset four cycles into MUL r0,r1
    issue(8'h81, 1'b0);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    repeat (3) begin
      @(negedge clk);
      #2;
      chk1("midrst_ready", instr_ready, 1'b1);
      chk1("midrst_busy", busy, 1'b0);
      chk8("midrst_res", res, 8'h00);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run(8'hB0, "post_rst_r0", 8'h00, 1'b0);
    run(8'hB1, "post_rst_r1", 8'h00, 1'b0);
    run(8'hB2, "post_rst_r2", 8'h00, 1'b0);
    run(8'hB3, "post_rst_r3", 8'h00, 1'b0);
    run(8'hD5, "post_rst_ldi", 8'h05, 1'b0);

    repeat (3) @(negedge clk);
    #3;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
